thermo_lock_monitor: RTL and testbench
======================================

Name: thermo_lock_monitor

Overview:
Streaming thermometer-code monitor for flash/DAC-style LSB-filled codes. Each valid input sample is classified as a legal thermometer code and decoded to a one-count level. A lock state machine tracks code health over consecutive samples, and a saturating error counter records illegal samples. It sits between a sampled thermometer bus and status/control logic, one cycle of latency.

Parameters:
DATA_WIDTH, 8, width of codeIn (>= 2)
ALLOW_EDGES, 0, 1: all-zeros and all-ones count as legal; 0: they are illegal
LOCK_CNT, 4, consecutive legal samples needed to enter LOCKED (>= 1)
MISS_CNT, 2, consecutive illegal samples needed to leave LOCKED (>= 1)
CNT_WIDTH, 8, width of err_count

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  codeIn carries a sample this cycle
codeIn  input  DATA_WIDTH  thermometer sample, LSB-filled
err_clr  input  1  synchronous clear of err_count
out_valid  output  1  registered; high one cycle after each in_valid cycle
isThermometer  output  1  registered legality of the sample
level  output  $clog2(DATA_WIDTH+1)  registered popcount of the sample
locked  output  1  registered lock state (1 = LOCKED)
err_count  output  CNT_WIDTH  saturating count of illegal samples

Behaviour:
- Single clock domain. Reset is synchronous and active-high. All outputs are registered.
- Legal code: codeIn == (1<<k)-1, with ones contiguous from bit 0.
  - k in 1..DATA_WIDTH-1 is always legal.
  - k=0 and k=DATA_WIDTH are legal only when ALLOW_EDGES=1.
  - MSB-filled codes (e.g. 8'b11110000) are illegal.
- level is the popcount of codeIn whether or not the sample is legal. This gives a bubble-tolerant estimate.
- Latency 1: for a sample with in_valid=1 in cycle N, out_valid=1, isThermometer, level and the updated locked/err_count are visible in cycle N+1.
- in_valid=0 in cycle N:
  - out_valid=0 in N+1.
  - isThermometer, level, locked, err_count, the FSM and the run counters all hold.
- Reset values: out_valid=0, isThermometer=0, level=0, locked=0, err_count=0, FSM=SEARCH, run counter=0.
- FSM states and transitions:
  - SEARCH (locked=0):
    - Legal sample: run counter +1. When it reaches LOCK_CNT, go to LOCKED and zero the counter.
    - Illegal sample: run counter returns to 0.
  - LOCKED (locked=1):
    - Illegal sample: miss counter +1. When it reaches MISS_CNT, go to SEARCH and zero the counter.
    - Legal sample: miss counter returns to 0.
  - locked changes in the same cycle as out_valid for the sample that completes the run.
  - LOCK_CNT=1 means the first legal sample locks.
- err_count:
  - +1 per illegal valid sample, counted in both FSM states.
  - Saturates at 2^CNT_WIDTH-1 and never wraps.
  - err_clr=1 sets it to 0 next cycle. Clear has priority over a simultaneous illegal sample, which is not counted.
  - err_clr does not affect the FSM.
- Reset mid-run: returns to the reset values next cycle. A sample presented during the reset cycle is discarded.

Test Plan:
- DATA_WIDTH=8, ALLOW_EDGES=0: samples 8'h01, 8'h7F, 8'h00, 8'hFF, 8'hF0, 8'h05 back-to-back.
  -> isThermometer 1,1,0,0,0,0; level 1,7,0,8,4,2; err_count ends at 4.
- LOCK_CNT=3, MISS_CNT=2: samples 0F,0F,33,0F,0F,0F.
  -> locked rises only on the out_valid cycle of the 6th sample; the illegal 33 restarts the run.
- While locked: samples 33,0F,33,33.
  -> stays locked after the single miss; locked falls on the out_valid cycle of the 4th sample.
- in_valid gaps: legal samples separated by idle cycles count as consecutive.
  -> lock is reached after LOCK_CNT valid samples; outputs hold across gaps.
- CNT_WIDTH=2: 5 illegal samples.
  -> err_count 1,2,3,3,3.
  - err_clr asserted together with an illegal sample -> err_count=0 next cycle.
- ALLOW_EDGES=1: 8'h00 and 8'hFF -> isThermometer=1.
  - reset asserted while locked -> next cycle locked=0, out_valid=0, err_count=0.

Source files
------------

// File: rtl/thermo_lock_monitor.sv
// Streaming thermometer-code monitor: legality check, popcount level,
// lock/miss state machine and a saturating illegal-sample counter, 1-cycle latency.
module thermo_lock_monitor #(
  parameter int DATA_WIDTH  = 8,
  parameter int ALLOW_EDGES = 0,
  parameter int LOCK_CNT    = 4,
  parameter int MISS_CNT    = 2,
  parameter int CNT_WIDTH   = 8,
  localparam int LVL_W      = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] codeIn,
  input  logic                  err_clr,
  output logic                  out_valid,
  output logic                  isThermometer,
  output logic [LVL_W-1:0]      level,
  output logic                  locked,
  output logic [CNT_WIDTH-1:0]  err_count
);

  // One counter serves both the lock run and the miss run; it is zeroed on every state change.
  localparam int RUN_MAX = (LOCK_CNT > MISS_CNT) ? LOCK_CNT : MISS_CNT;
  localparam int RUN_W   = (RUN_MAX < 2) ? 1 : $clog2(RUN_MAX);

  typedef enum logic [0:0] {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  function automatic logic is_legal(input logic [DATA_WIDTH-1:0] code);
    logic [DATA_WIDTH-1:0] inc;
    logic                  contiguous;
    logic                  edge_code;
    inc        = code + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    contiguous = ((code & inc) == {DATA_WIDTH{1'b0}});
    edge_code  = (code == {DATA_WIDTH{1'b0}}) || (code == {DATA_WIDTH{1'b1}});
    if (!contiguous) begin
      return 1'b0;
    end else if (edge_code && (ALLOW_EDGES == 0)) begin
      return 1'b0;
    end else begin
      return 1'b1;
    end
  endfunction

  function automatic logic [LVL_W-1:0] popcount(input logic [DATA_WIDTH-1:0] code);
    logic [LVL_W-1:0] acc;
    acc = {LVL_W{1'b0}};
    for (int i = 0; i < DATA_WIDTH; i++) begin
      acc = acc + LVL_W'(code[i]);
    end
    return acc;
  endfunction

  state_t               state_r, state_nxt_s;
  logic [RUN_W-1:0]     run_cnt_r, run_cnt_nxt_s;
  logic                 legal_s;
  logic [LVL_W-1:0]     pop_s;
  logic [CNT_WIDTH-1:0] err_r, err_nxt_s;
  logic                 out_valid_r, thermo_r, locked_r;
  logic [LVL_W-1:0]     level_r;

  assign legal_s = is_legal(codeIn);
  assign pop_s   = popcount(codeIn);

  // Lock state machine: next state and run counter.
  always_comb begin
    state_nxt_s   = state_r;
    run_cnt_nxt_s = run_cnt_r;
    if (in_valid) begin
      case (state_r)
        SEARCH: begin
          if (!legal_s) begin
            run_cnt_nxt_s = {RUN_W{1'b0}};
          end else if (run_cnt_r == RUN_W'(LOCK_CNT - 1)) begin
            state_nxt_s   = LOCKED;
            run_cnt_nxt_s = {RUN_W{1'b0}};
          end else begin
            run_cnt_nxt_s = run_cnt_r + RUN_W'(1);
          end
        end
        LOCKED: begin
          if (legal_s) begin
            run_cnt_nxt_s = {RUN_W{1'b0}};
          end else if (run_cnt_r == RUN_W'(MISS_CNT - 1)) begin
            state_nxt_s   = SEARCH;
            run_cnt_nxt_s = {RUN_W{1'b0}};
          end else begin
            run_cnt_nxt_s = run_cnt_r + RUN_W'(1);
          end
        end
        default: begin
          state_nxt_s   = SEARCH;
          run_cnt_nxt_s = {RUN_W{1'b0}};
        end
      endcase
    end else begin
      state_nxt_s   = state_r;
      run_cnt_nxt_s = run_cnt_r;
    end
  end

  // Error counter: clear wins over a same-cycle illegal sample; saturates at all-ones.
  always_comb begin
    err_nxt_s = err_r;
    if (err_clr) begin
      err_nxt_s = {CNT_WIDTH{1'b0}};
    end else if (in_valid && !legal_s && (err_r != {CNT_WIDTH{1'b1}})) begin
      err_nxt_s = err_r + CNT_WIDTH'(1);
    end else begin
      err_nxt_s = err_r;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= SEARCH;
      run_cnt_r   <= {RUN_W{1'b0}};
      err_r       <= {CNT_WIDTH{1'b0}};
      out_valid_r <= 1'b0;
      thermo_r    <= 1'b0;
      level_r     <= {LVL_W{1'b0}};
      locked_r    <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      run_cnt_r   <= run_cnt_nxt_s;
      err_r       <= err_nxt_s;
      out_valid_r <= in_valid;
      locked_r    <= (state_nxt_s == LOCKED);
      if (in_valid) begin
        thermo_r <= legal_s;
        level_r  <= pop_s;
      end
    end
  end

  assign out_valid     = out_valid_r;
  assign isThermometer = thermo_r;
  assign level         = level_r;
  assign locked        = locked_r;
  assign err_count     = err_r;

endmodule

// File: tb/tb_thermo_lock_monitor.sv
// Directed table-driven bench: DUT A (LOCK=3, MISS=2, edges illegal, 8-bit counter)
// and DUT B (LOCK=1, MISS=1, edges legal, 2-bit counter).
module tb_thermo_lock_monitor;

  typedef struct {
    logic       rst;
    logic       vld;
    logic       clr;
    logic [7:0] code;
    logic       e_ov;
    logic       e_th;
    logic [3:0] e_lvl;
    logic       e_lk;
    logic [7:0] e_err;
  } vec_t;

  logic       clk = 1'b0;
  logic       a_rst, a_vld, a_clr, b_rst, b_vld, b_clr;
  logic [7:0] a_code, b_code;
  logic       a_ov, a_th, a_lk, b_ov, b_th, b_lk;
  logic [3:0] a_lvl, b_lvl;
  logic [7:0] a_err;
  logic [1:0] b_err;

  int tests = 0;
  int fails = 0;
  vec_t va[$];
  vec_t vb[$];

  always #5 clk = ~clk;

  thermo_lock_monitor #(.DATA_WIDTH(8), .ALLOW_EDGES(0), .LOCK_CNT(3), .MISS_CNT(2), .CNT_WIDTH(8)) dut_a (
    .clk(clk), .reset(a_rst), .in_valid(a_vld), .codeIn(a_code), .err_clr(a_clr),
    .out_valid(a_ov), .isThermometer(a_th), .level(a_lvl), .locked(a_lk), .err_count(a_err)
  );

  thermo_lock_monitor #(.DATA_WIDTH(8), .ALLOW_EDGES(1), .LOCK_CNT(1), .MISS_CNT(1), .CNT_WIDTH(2)) dut_b (
    .clk(clk), .reset(b_rst), .in_valid(b_vld), .codeIn(b_code), .err_clr(b_clr),
    .out_valid(b_ov), .isThermometer(b_th), .level(b_lvl), .locked(b_lk), .err_count(b_err)
  );

  function automatic vec_t mk(input logic rst, input logic vld, input logic clr, input logic [7:0] code,
                              input logic ov, input logic th, input logic [3:0] lvl, input logic lk,
                              input logic [7:0] err);
    vec_t v;
    v.rst = rst; v.vld = vld; v.clr = clr; v.code = code;
    v.e_ov = ov; v.e_th = th; v.e_lvl = lvl; v.e_lk = lk; v.e_err = err;
    return v;
  endfunction

  task automatic chk(input string nm, input string dn, input int idx, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s %s row %0d: got %h, expected %h", dn, nm, idx, act, exp);
    end
  endtask

  task automatic apply(input int which, input vec_t v, input int idx);
    string dn;
    if (which == 0) begin
      a_rst = v.rst; a_vld = v.vld; a_clr = v.clr; a_code = v.code;
    end else begin
      b_rst = v.rst; b_vld = v.vld; b_clr = v.clr; b_code = v.code;
    end
    @(posedge clk);
    #1;
    if (which == 0) begin
      dn = "A";
      chk("out_valid", dn, idx, {7'd0, a_ov}, {7'd0, v.e_ov});
      chk("isThermometer", dn, idx, {7'd0, a_th}, {7'd0, v.e_th});
      chk("level", dn, idx, {4'd0, a_lvl}, {4'd0, v.e_lvl});
      chk("locked", dn, idx, {7'd0, a_lk}, {7'd0, v.e_lk});
      chk("err_count", dn, idx, a_err, v.e_err);
    end else begin
      dn = "B";
      chk("out_valid", dn, idx, {7'd0, b_ov}, {7'd0, v.e_ov});
      chk("isThermometer", dn, idx, {7'd0, b_th}, {7'd0, v.e_th});
      chk("level", dn, idx, {4'd0, b_lvl}, {4'd0, v.e_lvl});
      chk("locked", dn, idx, {7'd0, b_lk}, {7'd0, v.e_lk});
      chk("err_count", dn, idx, {6'd0, b_err}, v.e_err);
    end
  endtask

  initial begin
    a_rst = 1'b1; a_vld = 1'b0; a_clr = 1'b0; a_code = 8'h00;
    b_rst = 1'b1; b_vld = 1'b0; b_clr = 1'b0; b_code = 8'h00;

    //          rst   vld   clr   code   ov    th    lvl   lk    err
    va.push_back(mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 8'd0));
    // legality and popcount on mixed codes
    va.push_back(mk(1'b0, 1'b1, 1'b0, 8'h01, 1'b1, 1'b1, 4'd1, 1'b0, 8'd0));
    va.push_back(mk(1'b0, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1, 4'd7, 1'b0, 8'd0));
    va.push_back(mk(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 4'd0, 1'b0, 8'd1));
    va.push_back(mk(1'b0, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 4'd8, 1'b0, 8'd2));
    va.push_back(mk(1'b0, 1'b1, 1'b0, 8'hF0, 1'b1, 1'b0, 4'd4, 1'b0, 8'd3));
    va.push_back(mk(1'b0, 1'b1, 1'b0, 8'h05, 1'b1, 1'b0, 4'd2, 1'b0, 8'd4));
    // run restarted by an illegal sample, lock on the 3rd consecutive legal
    va.push_back(mk(1'b0, 1'b1, 1'b0, 8'h0F, 1'b1, 1'b1, 4'd4, 1'b0, 8'd4));
    va.push_back(mk(1'b0, 1'b1, 1'b0, 8'h0F, 1'b1, 1'b1, 4'd4, 1'b0, 8'd4));
    va.push_back(mk(1'b0, 1'b1, 1'b0, 8'h33, 1'b1, 1'b0, 4'd4, 1'b0, 8'd5));
    va.push_back(mk(1'b0, 1'b1, 1'b0, 8'h0F, 1'b1, 1'b1, 4'd4, 1'b0, 8'd5));
    va.push_back(mk(1'b0, 1'b1, 1'b0, 8'h0F, 1'b1, 1'b1, 4'd4, 1'b0, 8'd5));
    va.push_back(mk(1'b0, 1'b1, 1'b0, 8'h0F, 1'b1, 1'b1, 4'd4, 1'b1, 8'd5));
    // single miss tolerated, two consecutive misses unlock
    va.push_back(mk(1'b0, 1'b1, 1'b0, 8'h33, 1'b1, 1'b0, 4'd4, 1'b1, 8'd6));
    va.push_back(mk(1'b0, 1'b1, 1'b0, 8'h0F, 1'b1, 1'b1, 4'd4, 1'b1, 8'd6));
    va.push_back(mk(1'b0, 1'b1, 1'b0, 8'h33, 1'b1, 1'b0, 4'd4, 1'b1, 8'd7));
    va.push_back(mk(1'b0, 1'b1, 1'b0, 8'h33, 1'b1, 1'b0, 4'd4, 1'b0, 8'd8));
    // idle gaps hold outputs and do not break the run
    va.push_back(mk(1'b0, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0, 4'd4, 1'b0, 8'd8));
    va.push_back(mk(1'b0, 1'b1, 1'b0, 8'h03, 1'b1, 1'b1, 4'd2, 1'b0, 8'd8));
    va.push_back(mk(1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 4'd2, 1'b0, 8'd8));
    va.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 4'd2, 1'b0, 8'd8));
    va.push_back(mk(1'b0, 1'b1, 1'b0, 8'h07, 1'b1, 1'b1, 4'd3, 1'b0, 8'd8));
    va.push_back(mk(1'b0, 1'b0, 1'b0, 8'h33, 1'b0, 1'b1, 4'd3, 1'b0, 8'd8));
    va.push_back(mk(1'b0, 1'b1, 1'b0, 8'h01, 1'b1, 1'b1, 4'd1, 1'b1, 8'd8));
    // clear beats a simultaneous illegal sample; clear alone while idle
    va.push_back(mk(1'b0, 1'b1, 1'b1, 8'h33, 1'b1, 1'b0, 4'd4, 1'b1, 8'd0));
    va.push_back(mk(1'b0, 1'b1, 1'b0, 8'h0F, 1'b1, 1'b1, 4'd4, 1'b1, 8'd0));
    va.push_back(mk(1'b0, 1'b1, 1'b0, 8'h80, 1'b1, 1'b0, 4'd1, 1'b1, 8'd1));
    va.push_back(mk(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 4'd1, 1'b1, 8'd0));
    // reset while locked discards the sample; FSM restarts from SEARCH
    va.push_back(mk(1'b1, 1'b1, 1'b0, 8'h33, 1'b0, 1'b0, 4'd0, 1'b0, 8'd0));
    va.push_back(mk(1'b0, 1'b1, 1'b0, 8'h0F, 1'b1, 1'b1, 4'd4, 1'b0, 8'd0));
    va.push_back(mk(1'b0, 1'b1, 1'b0, 8'h0F, 1'b1, 1'b1, 4'd4, 1'b0, 8'd0));
    va.push_back(mk(1'b0, 1'b1, 1'b0, 8'h0F, 1'b1, 1'b1, 4'd4, 1'b1, 8'd0));

    // DUT B sequences: edges legal, first legal locks, first miss unlocks, 2-bit saturation
    vb.push_back(mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 8'd0));
    vb.push_back(mk(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 4'd0, 1'b1, 8'd0));
    vb.push_back(mk(1'b0, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b1, 4'd8, 1'b1, 8'd0));
    vb.push_back(mk(1'b0, 1'b1, 1'b0, 8'hF0, 1'b1, 1'b0, 4'd4, 1'b0, 8'd1));
    vb.push_back(mk(1'b0, 1'b1, 1'b0, 8'h05, 1'b1, 1'b0, 4'd2, 1'b0, 8'd2));
    vb.push_back(mk(1'b0, 1'b1, 1'b0, 8'h33, 1'b1, 1'b0, 4'd4, 1'b0, 8'd3));
    vb.push_back(mk(1'b0, 1'b1, 1'b0, 8'h80, 1'b1, 1'b0, 4'd1, 1'b0, 8'd3));
    vb.push_back(mk(1'b0, 1'b1, 1'b0, 8'h0A, 1'b1, 1'b0, 4'd2, 1'b0, 8'd3));
    vb.push_back(mk(1'b0, 1'b1, 1'b1, 8'h33, 1'b1, 1'b0, 4'd4, 1'b0, 8'd0));
    vb.push_back(mk(1'b0, 1'b1, 1'b0, 8'h01, 1'b1, 1'b1, 4'd1, 1'b1, 8'd0));
    vb.push_back(mk(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 8'd0));
    vb.push_back(mk(1'b0, 1'b1, 1'b0, 8'hFE, 1'b1, 1'b0, 4'd7, 1'b0, 8'd1));

    @(negedge clk);
    for (int i = 0; i < va.size(); i++) begin
      apply(0, va[i], i);
    end
    a_rst = 1'b0; a_vld = 1'b0; a_clr = 1'b0;
    for (int i = 0; i < vb.size(); i++) begin
      apply(1, vb[i], i);
    end
    b_rst = 1'b0; b_vld = 1'b0; b_clr = 1'b0;
    @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
